// File: rtl/mmio_poll_master.sv
// Polls a memory-mapped switch register, mirrors changes to the LED register
// and appends each change to a circular log in data memory.
module mmio_poll_master #(
  parameter logic [31:0] SW_ADDR   = 32'h0000_0300,
  parameter logic [31:0] LED_ADDR  = 32'h0000_0200,
  parameter logic [31:0] LOG_BASE  = 32'h0000_0000,
  parameter int unsigned LOG_DEPTH = 16,
  parameter int unsigned POLL_DIV  = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [31:0]                  readData,
  output logic [31:0]                  address,
  output logic [63:0]                  memAddress,
  output logic                         readEnable,
  output logic                         writeEnable,
  output logic [31:0]                  writeData,
  output logic                         busy,
  output logic [15:0]                  lastValue,
  output logic [15:0]                  changeCount,
  output logic [$clog2(LOG_DEPTH)-1:0] logPtr
);

  localparam int unsigned PW = $clog2(LOG_DEPTH);
  localparam int unsigned CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(POLL_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRdReq,
    StRdCap,
    StWrLed,
    StWrLog
  } state_e;

  state_e         state;
  logic [CW-1:0]  poll_cnt;
  logic           first_flag;
  logic [15:0]    sw_value;
  logic [31:0]    log_addr;
  logic           unused_rdata;

  assign sw_value     = readData[15:0];
  assign unused_rdata = ^readData[31:16];
  assign log_addr     = LOG_BASE + {{(30 - PW){1'b0}}, logPtr, 2'b00};
  assign busy         = (state != StIdle);

  // Bus outputs are registered: each transition loads the strobes of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      poll_cnt    <= '0;
      first_flag  <= 1'b1;
      lastValue   <= '0;
      changeCount <= '0;
      logPtr      <= '0;
      address     <= '0;
      memAddress  <= '0;
      readEnable  <= 1'b0;
      writeEnable <= 1'b0;
      writeData   <= '0;
    end else begin
      address     <= '0;
      memAddress  <= '0;
      readEnable  <= 1'b0;
      writeEnable <= 1'b0;
      writeData   <= '0;
      case (state)
        StIdle: begin
          if (enable) begin
            state    <= StWait;
            poll_cnt <= RELOAD;
          end
        end
        StWait: begin
          if (poll_cnt == '0) begin
            if (enable) begin
              state      <= StRdReq;
              address    <= SW_ADDR;
              readEnable <= 1'b1;
            end else begin
              state <= StIdle;
            end
          end else begin
            poll_cnt <= poll_cnt - CW'(1);
          end
        end
        StRdReq: begin
          state      <= StRdCap;
          address    <= SW_ADDR;
          readEnable <= 1'b1;
        end
        StRdCap: begin
          if (first_flag || (sw_value != lastValue)) begin
            lastValue   <= sw_value;
            first_flag  <= 1'b0;
            state       <= StWrLed;
            address     <= LED_ADDR;
            writeEnable <= 1'b1;
            writeData   <= {16'b0, sw_value};
          end else begin
            poll_cnt <= RELOAD;
            state    <= StWait;
          end
        end
        StWrLed: begin
          state       <= StWrLog;
          address     <= log_addr;
          memAddress  <= {32'b0, log_addr};
          writeEnable <= 1'b1;
          writeData   <= {changeCount, lastValue};
        end
        StWrLog: begin
          logPtr <= logPtr + PW'(1);
          if (changeCount != 16'hFFFF) changeCount <= changeCount + 16'd1;
          poll_cnt <= RELOAD;
          state    <= StWait;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/mmio_poll_master.md
MMIO_POLL_MASTER -- requirements
Module: mmio_poll_master

Interface
REQ-001 Parameter SW_ADDR, default 32'h0000_0300, switch register address.
REQ-002 Parameter LED_ADDR, default 32'h0000_0200, 7-segment/LED output register address.
REQ-003 Parameter LOG_BASE, default 32'h0000_0000, data-memory byte address of log entry 0.
REQ-004 Parameter LOG_DEPTH, default 16, number of log entries; power of two, 2..256.
REQ-005 Parameter POLL_DIV, default 1000, clk cycles spent in WAIT per poll; minimum 1.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 enable  input  1  level; polling runs while high.
REQ-009 readData  input  32  read return from the address decoder; valid in the cycle after readEnable first rises.
REQ-010 address  output  32  bus address to the address decoder.
REQ-011 memAddress  output  64  data-memory address; equals {32'b0, address} during WR_LOG, otherwise 0.
REQ-012 readEnable  output  1  bus read strobe.
REQ-013 writeEnable  output  1  bus write strobe.
REQ-014 writeData  output  32  bus write data.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 lastValue  output  16  most recently captured switch value.
REQ-017 changeCount  output  16  number of logged changes; saturates at 16'hFFFF.
REQ-018 logPtr  output  log2(LOG_DEPTH)  index of the next log entry to write.

Function
REQ-019 FSM states: IDLE, WAIT, RD_REQ, RD_CAP, WR_LED, WR_LOG.
REQ-020 IDLE: all strobes low; on enable=1 go to WAIT and load pollCnt=POLL_DIV-1.
REQ-021 WAIT: decrement pollCnt each cycle; at pollCnt=0 go to RD_REQ if enable=1, else go to IDLE.
REQ-022 RD_REQ: address=SW_ADDR, readEnable=1; next state is RD_CAP.
REQ-023 RD_CAP: address=SW_ADDR, readEnable=1; capture readData[15:0] at the end of the cycle.
REQ-024 After RD_CAP: go to WR_LED if the captured value differs from lastValue or the firstFlag is set; otherwise reload pollCnt and go to WAIT.
REQ-025 lastValue updates only on a detected change; firstFlag clears on the first transition to WR_LED.
REQ-026 WR_LED: one cycle; address=LED_ADDR, writeEnable=1, writeData={16'b0, value}.
REQ-027 WR_LOG: one cycle; address=LOG_BASE+4*logPtr, memAddress={32'b0, address}, writeEnable=1, writeData={changeCount[15:0], value}, where changeCount is the pre-increment value.
REQ-028 Exit from WR_LOG: logPtr increments modulo LOG_DEPTH (LOG_DEPTH-1 wraps to 0); changeCount increments, saturating at 16'hFFFF; pollCnt reloads; go to WAIT.
REQ-029 readEnable and writeEnable are never high in the same cycle.
REQ-030 When no strobe is active: address=0, memAddress=0, writeData=0.
REQ-031 A transaction started in RD_REQ always completes through WAIT; enable is sampled only in IDLE and at WAIT expiry.
REQ-032 POLL_DIV=1: the block spends exactly one cycle in WAIT.
REQ-033 A switch change lasting less than one poll period can be missed; this is required behaviour, not an error.

Reset
REQ-034 rst=1 immediately forces the state to IDLE and drives all strobes low, regardless of state and without waiting for a clock edge.
REQ-035 During reset, the following are 0: pollCnt, lastValue, changeCount, logPtr, address, memAddress, writeData, busy.
REQ-036 Reset sets firstFlag=1.
REQ-037 Reset asserted mid-write (WR_LED or WR_LOG) aborts the write; no retry occurs after release.

Verification
REQ-038 POLL_DIV=4, enable=1, switches at 16'h00A5 -> first poll: readEnable for 2 cycles, then WR_LED with writeData=32'h0000_00A5, then WR_LOG at address 0 with writeData=32'h0000_00A5; changeCount=1, logPtr=1.
REQ-039 Switches unchanged across 3 further polls -> no writeEnable; changeCount stays 1; WAIT lasts exactly 4 cycles between reads.
REQ-040 Switch values change 17 times with LOG_DEPTH=16 -> log addresses step 0,4,...,60 then return to 0; logPtr wraps to 1 after the 17th change.
REQ-041 enable dropped during RD_CAP -> the change is still written to LED and log, then the block reaches IDLE at WAIT expiry with busy=0.
REQ-042 rst pulsed during WR_LOG -> writeEnable falls the same cycle; all counters are 0; the first poll after release logs the current value even if unchanged.
REQ-043 All tests: a cycle-by-cycle checker flags any cycle in which readEnable and writeEnable are both high.
